// File: rtl/agc_att_ctrl_if.sv
// Sample/control bundle between the ADC capture block and the AGC attenuator controller.
interface agc_att_ctrl_if;
  logic        en;
  logic        manual;
  logic [5:0]  manual_att;
  logic        sample_valid;
  logic [11:0] sample;
  logic        otr;
  logic [5:0]  att_db;
  logic [5:0]  att_v;
  logic [11:0] peak;
  logic        peak_valid;
  logic        locked;
  logic        busy;

  modport master (
    output en, manual, manual_att, sample_valid, sample, otr,
    input  att_db, att_v, peak, peak_valid, locked, busy
  );

  modport slave (
    input  en, manual, manual_att, sample_valid, sample, otr,
    output att_db, att_v, peak, peak_valid, locked, busy
  );
endinterface

// File: rtl/agc_att_ctrl.sv
// AGC for the RF step attenuator: windowed peak detect, stepped attenuation, settle, lock.
// Optional macro AGC_OTR_FAST_EN: an over-range sample aborts the current window at once.
module agc_att_ctrl #(
  parameter int WIN_LOG2   = 12,
  parameter int SETTLE_CYC = 256,
  parameter int HI_THR     = 1800,
  parameter int LO_THR     = 600,
  parameter int STEP       = 1,
  parameter int FAST_STEP  = 4,
  parameter int LOCK_WIN   = 4
) (
  input logic           clk,
  input logic           rst,
  agc_att_ctrl_if.slave bus
);
  localparam int          SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int          LOCK_W   = $clog2(LOCK_WIN + 1);
  localparam logic [11:0] HI       = 12'(HI_THR);
  localparam logic [11:0] LO       = 12'(LO_THR);
  localparam logic [11:0] MID      = 12'd2048;
  localparam logic [6:0]  ATT_MAX  = 7'd63;

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} state_t;
  state_t state, state_nxt;

  logic [WIN_LOG2-1:0] win_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [LOCK_W-1:0]   inband_cnt;
  logic [11:0]         acc, mag, peak_r;
  logic                otr_seen, peak_valid_r;
  logic [5:0]          att, att_nxt;
  logic [6:0]          att_wide;
  logic                run, win_done, otr_abort, settle_done, in_band;

  assign mag         = (bus.sample >= MID) ? bus.sample - MID : MID - bus.sample;
  assign run         = bus.en & ~bus.manual;
  assign win_done    = (state == MEASURE) && bus.sample_valid && (&win_cnt);
  assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYC - 1));
  assign in_band     = ~otr_seen && (acc >= LO) && (acc <= HI);

`ifdef AGC_OTR_FAST_EN
  assign otr_abort = (state == MEASURE) && bus.sample_valid && bus.otr;
`else
  assign otr_abort = 1'b0;
`endif

  // Attenuation request in 7 bits so the +FAST_STEP overflow past 63 is visible before clamping.
  always_comb begin
    att_wide = {1'b0, att};
    if (otr_seen)
      att_wide = att_wide + 7'(FAST_STEP);
    else if (acc > HI)
      att_wide = att_wide + 7'(STEP);
    else if (acc < LO)
      att_wide = (att_wide >= 7'(STEP)) ? att_wide - 7'(STEP) : 7'd0;
    att_nxt = (att_wide > ATT_MAX) ? 6'd63 : att_wide[5:0];
  end

  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = MEASURE;
        MEASURE: if (win_done || otr_abort) state_nxt = DECIDE;
        DECIDE:  state_nxt = (att_nxt != att) ? SETTLE : MEASURE;
        SETTLE:  if (settle_done) state_nxt = MEASURE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      win_cnt      <= '0;
      settle_cnt   <= '0;
      inband_cnt   <= '0;
      acc          <= '0;
      peak_r       <= '0;
      otr_seen     <= 1'b0;
      peak_valid_r <= 1'b0;
      att          <= '0;
    end else begin
      state        <= state_nxt;
      peak_valid_r <= 1'b0;
      if (bus.manual) begin
        att        <= bus.manual_att;
        inband_cnt <= '0;
      end else if (!bus.en) begin
        inband_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            win_cnt  <= '0;
            acc      <= '0;
            otr_seen <= 1'b0;
          end
          MEASURE: begin
            if (bus.sample_valid) begin
              win_cnt <= win_cnt + 1'b1;
              if (mag > acc) acc <= mag;
              if (bus.otr) otr_seen <= 1'b1;
`ifdef AGC_OTR_FAST_EN
              if (bus.otr) acc <= MID;
`endif
            end
          end
          // Every exit from DECIDE starts a fresh window, whether or not SETTLE comes first.
          DECIDE: begin
            peak_r       <= acc;
            peak_valid_r <= 1'b1;
            att          <= att_nxt;
            if (!in_band)
              inband_cnt <= '0;
            else if (inband_cnt != LOCK_W'(LOCK_WIN))
              inband_cnt <= inband_cnt + 1'b1;
            win_cnt    <= '0;
            acc        <= '0;
            otr_seen   <= 1'b0;
            settle_cnt <= '0;
          end
          SETTLE: settle_cnt <= settle_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.att_db     = att;
  assign bus.att_v      = ~att;
  assign bus.peak       = peak_r;
  assign bus.peak_valid = peak_valid_r;
  assign bus.locked     = (inband_cnt == LOCK_W'(LOCK_WIN));
  assign bus.busy       = (state != IDLE);
endmodule
